elevator_look_scheduler: RTL and testbench
==========================================

// Module: elevator_look_scheduler
// PURPOSE
//  Request scheduler for the single-car elevator: latches hall (up/down) and car calls,
//  runs a LOOK policy, issues one-floor move commands to the motion unit and times door dwell.
//  Sits between button/LED top level and motion/7-seg units; owns cur_floor and busy.
// PARAMETERS
//  N_FLOORS    5   number of floors, 0..N_FLOORS-1
//  FLOOR_W     3   width of floor index, >= clog2(N_FLOORS)
//  DOOR_TICKS  3   door dwell length in tick pulses (>=1)
// PORTS
//  clk           in   1        system clock
//  rst           in   1        synchronous, active-high reset
//  tick          in   1        single-cycle timebase enable (e.g. 1 Hz) for door dwell
//  hall_up_req   in   N_FLOORS level, up hall call per floor; bit N_FLOORS-1 ignored
//  hall_dn_req   in   N_FLOORS level, down hall call per floor; bit 0 ignored
//  car_req       in   N_FLOORS level, in-car destination per floor
//  move_req      out  1        request motion unit to move one floor; held until move_ack
//  move_up       out  1        direction of move_req (1 up, 0 down); stable while move_req
//  move_ack      in   1        single-cycle pulse: car reached adjacent floor
//  cur_floor     out  FLOOR_W  current floor index
//  door_open     out  1        door open (dwell in progress)
//  busy          out  1        1 whenever state != IDLE
//  hall_pending  out  N_FLOORS latched hall calls (up|dn) -> outside LEDs
//  car_pending   out  N_FLOORS latched car calls -> inside LEDs
//  dir_state     out  2        00 idle, 01 up, 10 down
// BEHAVIOUR
//  Reset: state IDLE, cur_floor 0, all pending 0, move_req/move_up/door_open/busy 0, dir 00.
//  rst mid-move/mid-dwell: same values next cycle; motion unit is reset alongside.
//  Latching: any request bit high at a posedge sets its pending bit (1-cycle latency);
//   exception: press for cur_floor while DOOR restarts dwell count and is not latched.
//  FSM states IDLE, MOVE, DOOR; registered dir (UP/DN/NONE).
//  IDLE: pending at cur_floor -> DOOR. Else nearest pending floor sets dir (tie -> UP),
//   -> MOVE. No pending -> stay, dir NONE.
//  MOVE: move_req=1, move_up=(dir==UP). On move_ack: cur_floor +/-1 same edge, move_req
//   drops 1 cycle to evaluate stop at new floor f. Stop if car_pending[f], or hall call
//   in dir at f, or opposite hall call at f with nothing pending beyond f in dir, or f is
//   an end floor. Stop -> DOOR; else move_req reasserts next cycle.
//  move_ack while move_req=0: ignored. Never command below floor 0 / above top.
//  DOOR: on entry clear car_pending[f], hall_up[f], hall_dn[f]; door_open=1; count
//   DOOR_TICKS tick pulses. On expiry: pending ahead in dir -> MOVE same dir; else pending
//   behind -> MOVE reversed; else -> IDLE, dir NONE. door_open and move_req never both 1.
//  Simultaneous latch and clear for same bit on DOOR entry: clear wins.
//  tick coincident with restart press: restart wins (count reloads to 0).
// STRUCTURE
//  elevator_pkg: N_FLOORS/FLOOR_W defaults, dir_t {NONE,UP,DN}, state_t {IDLE,MOVE,DOOR}.
//  Sub-module door_dwell_timer (start/restart, tick, DOOR_TICKS -> done pulse).
//  Pending-above/below masks computed combinationally from cur_floor; no extra pipeline.
// TESTING
//  1 Reset, idle at 0, car_req[3] pulse -> dir 01, move_req; 3 acks -> cur_floor 3,
//    door_open for 3 ticks, car_pending[3] cleared, back to IDLE, busy 0.
//  2 At floor 0, hall_up_req[1] + hall_dn_req[3] + car_req[4] -> stops 1,4 then
//    reverses, stops 3; never stops 3 while going up.
//  3 Idle at 2, car_req[0] and car_req[4] same cycle -> tie, goes UP to 4 first, then 0.
//  4 During dwell at 2, hall_up_req[2] on tick 2 -> dwell restarts, 3 further ticks, no pending bit.
//  5 move_ack pulse while door_open -> cur_floor unchanged; top-floor hall_up bit ignored.
//  6 rst asserted mid-MOVE -> next cycle cur_floor 0, pending 0, move_req 0, IDLE.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and default sizes for the single-car elevator scheduler.
package elevator_pkg;

  localparam int N_FLOORS_DEF   = 5;
  localparam int FLOOR_W_DEF    = 3;
  localparam int DOOR_TICKS_DEF = 3;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    UP   = 2'b01,
    DN   = 2'b10
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MOVE = 2'b01,
    DOOR = 2'b10
  } state_t;

endpackage

// File: rtl/elevator_look_scheduler_door_dwell_timer.sv
// Door dwell timer: counts tick pulses after start, pulses done on the last one.
module door_dwell_timer
  import elevator_pkg::*;
#(
  parameter int DOOR_TICKS = DOOR_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic tick,
  output logic done
);

  localparam int CW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;

  logic [CW-1:0] cnt;
  logic          active;
  logic          last;

  assign last = (cnt == CW'(DOOR_TICKS - 1));

  // a (re)start in the same cycle as the final tick keeps the door open
  assign done = active && tick && last && !start;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      active <= 1'b1;
    end else if (active && tick) begin
      if (last) begin
        active <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/elevator_look_scheduler.sv
// LOOK request scheduler: latches hall/car calls, issues one-floor moves,
// and holds the door open for a tick-counted dwell at each stop.
module elevator_look_scheduler
  import elevator_pkg::*;
#(
  parameter int N_FLOORS   = N_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF,
  parameter int DOOR_TICKS = DOOR_TICKS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [N_FLOORS-1:0] hall_up_req,
  input  logic [N_FLOORS-1:0] hall_dn_req,
  input  logic [N_FLOORS-1:0] car_req,
  output logic                move_req,
  output logic                move_up,
  input  logic                move_ack,
  output logic [FLOOR_W-1:0]  cur_floor,
  output logic                door_open,
  output logic                busy,
  output logic [N_FLOORS-1:0] hall_pending,
  output logic [N_FLOORS-1:0] car_pending,
  output logic [1:0]          dir_state
);

  localparam logic [FLOOR_W-1:0]  TOP   = FLOOR_W'(N_FLOORS - 1);
  localparam logic [N_FLOORS-1:0] UP_OK = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_OK = {{(N_FLOORS-1){1'b1}}, 1'b0};

  state_t state;
  dir_t   dir;

  logic [N_FLOORS-1:0] hall_up;
  logic [N_FLOORS-1:0] hall_dn;
  logic [N_FLOORS-1:0] car_p;
  logic [N_FLOORS-1:0] pend;
  logic [N_FLOORS-1:0] up_in;
  logic [N_FLOORS-1:0] dn_in;
  logic [N_FLOORS-1:0] here;
  logic [N_FLOORS-1:0] above;
  logic [N_FLOORS-1:0] below;
  logic [N_FLOORS-1:0] lat_mask;
  logic [N_FLOORS-1:0] clr_mask;
  logic [FLOOR_W-1:0]  up_dist;
  logic [FLOOR_W-1:0]  dn_dist;

  logic any_here;
  logic any_above;
  logic any_below;
  logic near_up;
  logic beyond;
  logic same_hall;
  logic opp_hall;
  logic stop_here;
  logic press_here;
  logic door_enter;
  logic restart;
  logic dwell_done;
  logic ahead;
  logic behind;

  assign up_in = hall_up_req & UP_OK;
  assign dn_in = hall_dn_req & DN_OK;
  assign pend  = hall_up | hall_dn | car_p;

  // floor masks relative to the car, plus distance to nearest call each way
  always_comb begin
    here    = '0;
    above   = '0;
    below   = '0;
    up_dist = '0;
    dn_dist = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      here[i]  = (FLOOR_W'(i) == cur_floor);
      above[i] = (FLOOR_W'(i) > cur_floor);
      below[i] = (FLOOR_W'(i) < cur_floor);
      if (pend[i] && above[i]) begin
        up_dist = FLOOR_W'(i) - cur_floor;
      end
    end
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pend[i] && below[i]) begin
        dn_dist = cur_floor - FLOOR_W'(i);
      end
    end
  end

  assign any_here  = |(pend & here);
  assign any_above = |(pend & above);
  assign any_below = |(pend & below);
  assign near_up   = any_above && (!any_below || (up_dist <= dn_dist));

  assign beyond    = (dir == UP) ? any_above : any_below;
  assign same_hall = (dir == UP) ? |(hall_up & here) : |(hall_dn & here);
  assign opp_hall  = (dir == UP) ? |(hall_dn & here) : |(hall_up & here);

  assign stop_here = |(car_p & here) || same_hall ||
                     (opp_hall && !beyond) ||
                     (cur_floor == '0) || (cur_floor == TOP);

  assign ahead  = ((dir == UP) && any_above) || ((dir == DN) && any_below);
  assign behind = ((dir == UP) && any_below) || ((dir == DN) && any_above);

  assign door_enter = ((state == IDLE) && any_here) ||
                      ((state == MOVE) && !move_req && stop_here);

  assign press_here = |((up_in | dn_in | car_req) & here);
  assign restart    = (state == DOOR) && press_here;

  // calls at the open door only restart the dwell; entry clears the floor
  assign lat_mask = (state == DOOR) ? ~here : '1;
  assign clr_mask = door_enter ? here : '0;

  door_dwell_timer #(
    .DOOR_TICKS(DOOR_TICKS)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .start(door_enter | restart),
    .tick (tick),
    .done (dwell_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= NONE;
      cur_floor <= '0;
      hall_up   <= '0;
      hall_dn   <= '0;
      car_p     <= '0;
      move_req  <= 1'b0;
      move_up   <= 1'b0;
    end else begin
      hall_up <= (hall_up | (up_in & lat_mask)) & ~clr_mask;
      hall_dn <= (hall_dn | (dn_in & lat_mask)) & ~clr_mask;
      car_p   <= (car_p | (car_req & lat_mask)) & ~clr_mask;
      unique case (state)
        IDLE: begin
          if (door_enter) begin
            state <= DOOR;
          end else if (any_above || any_below) begin
            state    <= MOVE;
            move_req <= 1'b1;
            move_up  <= near_up;
            dir      <= near_up ? UP : DN;
          end else begin
            dir <= NONE;
          end
        end
        MOVE: begin
          if (move_req) begin
            if (move_ack) begin
              move_req  <= 1'b0;
              cur_floor <= move_up ? cur_floor + FLOOR_W'(1)
                                   : cur_floor - FLOOR_W'(1);
            end
          end else if (door_enter) begin
            state <= DOOR;
          end else begin
            move_req <= 1'b1;
          end
        end
        DOOR: begin
          if (dwell_done) begin
            if (ahead) begin
              state    <= MOVE;
              move_req <= 1'b1;
              move_up  <= (dir == UP);
            end else if (behind) begin
              state    <= MOVE;
              move_req <= 1'b1;
              move_up  <= (dir == DN);
              dir      <= (dir == UP) ? DN : UP;
            end else begin
              state <= IDLE;
              dir   <= NONE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          dir      <= NONE;
          move_req <= 1'b0;
        end
      endcase
    end
  end

  assign door_open    = (state == DOOR);
  assign busy         = (state != IDLE);
  assign hall_pending = hall_up | hall_dn;
  assign car_pending  = car_p;
  assign dir_state    = dir;

endmodule

// File: tb/tb_elevator_look_scheduler.sv
// Bench for elevator_look_scheduler: stop-floor scoreboard fed by a LOOK
// reference model, plus directed dwell, restart, ignore and reset scenarios.
module tb_elevator_look_scheduler;

  localparam int NF = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic [NF-1:0] hall_up_req = '0;
  logic [NF-1:0] hall_dn_req = '0;
  logic [NF-1:0] car_req = '0;
  logic          move_req;
  logic          move_up;
  logic          move_ack = 1'b0;
  logic [2:0]    cur_floor;
  logic          door_open;
  logic          busy;
  logic [NF-1:0] hall_pending;
  logic [NF-1:0] car_pending;
  logic [1:0]    dir_state;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit tick_auto = 1'b0;
  bit ack_en = 1'b1;
  bit prev_door = 1'b0;
  int tdiv = 0;
  int ack_wait = 0;
  int mfloor = 0;

  elevator_look_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .hall_up_req (hall_up_req),
    .hall_dn_req (hall_dn_req),
    .car_req     (car_req),
    .move_req    (move_req),
    .move_up     (move_up),
    .move_ack    (move_ack),
    .cur_floor   (cur_floor),
    .door_open   (door_open),
    .busy        (busy),
    .hall_pending(hall_pending),
    .car_pending (car_pending),
    .dir_state   (dir_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // one cycle: motion-unit ack emulation and timebase, all inputs from here
  task automatic step();
    @(negedge clk);
    if (move_ack) begin
      move_ack = 1'b0;
    end else if (ack_en && move_req) begin
      if (ack_wait == 0) begin
        move_ack = 1'b1;
        ack_wait = $urandom_range(0, 3);
      end else begin
        ack_wait--;
      end
    end
    tick = 1'b0;
    if (tick_auto) begin
      tdiv++;
      if (tdiv >= 4) begin
        tdiv = 0;
        tick = 1'b1;
      end
    end
  endtask

  task automatic tick_once();
    step();
    tick = 1'b1;
    step();
  endtask

  task automatic press(input logic [NF-1:0] u, input logic [NF-1:0] d,
                       input logic [NF-1:0] c);
    step();
    hall_up_req = u;
    hall_dn_req = d;
    car_req     = c;
    step();
    hall_up_req = '0;
    hall_dn_req = '0;
    car_req     = '0;
  endtask

  task automatic wait_for_door(input int budget);
    int n;
    n = 0;
    while (!door_open && n < budget) begin
      step();
      n++;
    end
    chk("door_reached", int'(door_open), 1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !busy && !door_open &&
             hall_pending == '0 && car_pending == '0) && n < budget) begin
      step();
      n++;
    end
    chk("batch_done", int'(n < budget), 1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_floor"}, int'(cur_floor), 0);
    chk({tag, "_hall"}, int'(hall_pending), 0);
    chk({tag, "_car"}, int'(car_pending), 0);
    chk({tag, "_move_req"}, int'(move_req), 0);
    chk({tag, "_move_up"}, int'(move_up), 0);
    chk({tag, "_door"}, int'(door_open), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_dir"}, int'(dir_state), 0);
  endtask

  function automatic bit pend_dir(input logic [NF-1:0] p, input int f,
                                  input int dir);
    for (int j = 0; j < NF; j++) begin
      if (p[j] && ((dir > 0 && j > f) || (dir < 0 && j < f))) return 1'b1;
    end
    return 1'b0;
  endfunction

  // LOOK reference: walk floor by floor, push every floor where the car stops
  function automatic void look(input int s, input logic [NF-1:0] u0,
                               input logic [NF-1:0] d0,
                               input logic [NF-1:0] c0, output int last);
    logic [NF-1:0] u, d, c, p;
    int f, dir, guard;
    bit stop, beyond;
    u = u0;
    d = d0;
    c = c0;
    u[NF-1] = 1'b0;
    d[0] = 1'b0;
    f = s;
    last = s;
    if (u[f] || d[f] || c[f]) begin
      exp_q.push_back(f);
      u[f] = 1'b0;
      d[f] = 1'b0;
      c[f] = 1'b0;
    end
    p = u | d | c;
    if (p == '0) return;
    dir = 0;
    for (int k = 1; k < NF && dir == 0; k++) begin
      if (s + k < NF && p[s+k]) dir = 1;
      else if (s - k >= 0 && p[s-k]) dir = -1;
    end
    guard = 0;
    while ((u | d | c) != '0 && guard < 100) begin
      guard++;
      f += dir;
      if (f < 0 || f >= NF) break;
      p = u | d | c;
      beyond = pend_dir(p, f, dir);
      stop = c[f] || (dir > 0 ? u[f] : d[f]) ||
             ((dir > 0 ? d[f] : u[f]) && !beyond) || f == 0 || f == NF - 1;
      if (stop) begin
        exp_q.push_back(f);
        u[f] = 1'b0;
        d[f] = 1'b0;
        c[f] = 1'b0;
        p = u | d | c;
        if (!pend_dir(p, f, dir) && pend_dir(p, f, -dir)) dir = -dir;
      end
    end
    last = f;
  endfunction

  initial begin : monitor
    forever begin
      @(negedge clk);
      chk("door_move_excl", int'(door_open && move_req), 0);
      if (door_open && !prev_door) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_stop", int'(cur_floor), -1);
        end else begin
          chk("stop_floor", int'(cur_floor), exp_q.pop_front());
          chk("stop_clear", int'(hall_pending[cur_floor] |
                                 car_pending[cur_floor]), 0);
        end
      end
      prev_door = door_open;
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst = 1'b1;
    step();
    step();
    check_reset("reset");
    rst = 1'b0;

    // car call to 3 from 0, manual ticks to measure the dwell
    tick_auto = 1'b0;
    ack_en = 1'b1;
    exp_q.push_back(3);
    press('0, '0, 5'b01000);
    step();
    chk("t1_dir", int'(dir_state), 1);
    chk("t1_move_req", int'(move_req), 1);
    wait_for_door(200);
    chk("t1_floor", int'(cur_floor), 3);
    chk("t1_car_clr", int'(car_pending[3]), 0);
    tick_once();
    tick_once();
    chk("t1_door_2ticks", int'(door_open), 1);
    tick_once();
    chk("t1_door_3ticks", int'(door_open), 0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_dir_idle", int'(dir_state), 0);

    // up-sweep skips the down call at 3, collects it after reversing
    rst = 1'b1;
    step();
    rst = 1'b0;
    tick_auto = 1'b1;
    exp_q.push_back(1);
    exp_q.push_back(4);
    exp_q.push_back(3);
    press(5'b00010, 5'b01000, 5'b10000);
    wait_done(2000);

    // equidistant calls from 2 go up first
    exp_q.push_back(2);
    press('0, '0, 5'b00100);
    wait_done(2000);
    exp_q.push_back(4);
    exp_q.push_back(0);
    press('0, '0, 5'b10001);
    step();
    chk("t3_tie_dir", int'(dir_state), 1);
    wait_done(2000);

    // same-floor press on the second tick restarts the dwell
    tick_auto = 1'b0;
    exp_q.push_back(2);
    press('0, '0, 5'b00100);
    wait_for_door(200);
    tick_once();
    step();
    tick = 1'b1;
    hall_up_req = 5'b00100;
    step();
    hall_up_req = '0;
    chk("t4_door_restart", int'(door_open), 1);
    chk("t4_no_latch", int'(hall_pending[2]), 0);
    tick_once();
    tick_once();
    chk("t4_door_after_2", int'(door_open), 1);
    tick_once();
    chk("t4_door_after_3", int'(door_open), 0);

    // stray ack at the open door; unreachable hall bits ignored
    ack_en = 1'b0;
    exp_q.push_back(2);
    press('0, '0, 5'b00100);
    wait_for_door(50);
    step();
    move_ack = 1'b1;
    step();
    chk("t5_floor_kept", int'(cur_floor), 2);
    chk("t5_door_kept", int'(door_open), 1);
    tick_once();
    tick_once();
    tick_once();
    chk("t5_door_closed", int'(door_open), 0);
    press(5'b10000, 5'b00001, '0);
    step();
    chk("t5_end_hall_ignored", int'(hall_pending), 0);
    chk("t5_busy", int'(busy), 0);

    // reset in the middle of a move
    ack_en = 1'b1;
    tick_auto = 1'b1;
    press('0, '0, 5'b10000);
    begin
      int n;
      n = 0;
      while (!(move_req && cur_floor == 3'd3) && n < 200) begin
        step();
        n++;
      end
      chk("t6_mid_move", int'(move_req && cur_floor == 3'd3), 1);
    end
    rst = 1'b1;
    step();
    check_reset("t6");
    rst = 1'b0;
    move_ack = 1'b0;
    exp_q.delete();
    mfloor = 0;

    // random call batches against the LOOK model
    for (int b = 0; b < 30; b++) begin
      logic [NF-1:0] u, d, c;
      int last;
      u = NF'($urandom & $urandom);
      d = NF'($urandom & $urandom);
      c = NF'($urandom & $urandom);
      look(mfloor, u, d, c, last);
      press(u, d, c);
      wait_done(4000);
      mfloor = last;
    end

    step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
